// File: rtl/usb_packet_transmitter.sv
// Purpose: packetizes a 32-bit word into header + 4 data bytes (+ XOR checksum when USB_TX_CHECKSUM_EN is defined).
// Latency: header valid the cycle after the load; one byte per cycle while tx_ready=1; all outputs registered.
// Backpressure: tx_ready=0 holds tx_data/state; loads while busy are dropped and flagged with overrun.
module usb_packet_transmitter #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        output_ready,
    input  logic [31:0] average_data,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        packet_done,
    output logic        overrun
);

`ifdef USB_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE} state_t;
`endif

    state_t      state, state_d;
    logic [31:0] shift, shift_d;
    logic [1:0]  cnt, cnt_d;
    logic        xfer;

    logic [7:0]  tx_data_d;
    logic        tx_valid_d;
    logic        busy_d;
    logic        packet_done_d;
    logic        overrun_d;

`ifdef USB_TX_CHECKSUM_EN
    logic [7:0]  csum, csum_d;
`endif

    // tx_valid is a register, so the handshake never loops back combinationally
    assign xfer = tx_valid & tx_ready;

    always_comb begin
        state_d = state;
        shift_d = shift;
        cnt_d   = cnt;
`ifdef USB_TX_CHECKSUM_EN
        csum_d  = csum;
`endif
        case (state)
            IDLE: begin
                if (output_ready) begin
                    shift_d = average_data;
                    cnt_d   = 2'd0;
`ifdef USB_TX_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    cnt_d   = 2'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef USB_TX_CHECKSUM_EN
                    csum_d  = csum ^ shift[31:24];
`endif
                    shift_d = {shift[23:0], 8'h00};
                    cnt_d   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
`ifdef USB_TX_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef USB_TX_CHECKSUM_EN
            CHECK: begin
                if (xfer) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they are registered yet cycle-aligned
    always_comb begin
        tx_data_d     = 8'h00;
        tx_valid_d    = 1'b0;
        busy_d        = (state_d != IDLE);
        packet_done_d = (state_d == DONE);
        overrun_d     = output_ready && (state != IDLE);
        case (state_d)
            HEADER: begin
                tx_data_d  = HEADER_BYTE;
                tx_valid_d = 1'b1;
            end
            DATA: begin
                tx_data_d  = shift_d[31:24];
                tx_valid_d = 1'b1;
            end
`ifdef USB_TX_CHECKSUM_EN
            CHECK: begin
                tx_data_d  = csum_d;
                tx_valid_d = 1'b1;
            end
`endif
            default: begin
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            shift       <= 32'h0;
            cnt         <= 2'd0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            packet_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            shift       <= shift_d;
            cnt         <= cnt_d;
            tx_data     <= tx_data_d;
            tx_valid    <= tx_valid_d;
            busy        <= busy_d;
            packet_done <= packet_done_d;
            overrun     <= overrun_d;
        end
    end

`ifdef USB_TX_CHECKSUM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) csum <= 8'h00;
        else        csum <= csum_d;
    end
`endif

endmodule

// File: tb/tb_usb_packet_transmitter.sv
// Self-checking bench for usb_packet_transmitter: directed scenarios plus random words and random backpressure.
module tb_usb_packet_transmitter;

`ifdef USB_TX_CHECKSUM_EN
    localparam int PKT_LEN = 6;
`else
    localparam int PKT_LEN = 5;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        output_ready = 1'b0;
    logic [31:0] average_data = 32'h0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        packet_done;
    logic        overrun;

    int n_asserts = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    usb_packet_transmitter dut (
        .clk(clk), .n_rst(n_rst), .output_ready(output_ready), .average_data(average_data),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
        .packet_done(packet_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packet: header, word bytes MSB first, optional XOR of the data bytes
    task automatic build_expected(input logic [31:0] w);
        logic [7:0] cs;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'((w >> (24 - 8 * i)) & 32'hFF);
            exp_q.push_back(b);
            cs = cs ^ b;
        end
`ifdef USB_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // Loads w, then runs the handshake until packet_done; cycle 1 is the cycle after the load edge.
    // ss/sl force tx_ready low for sl cycles from cycle ss; ovr_cyc pulses output_ready in that cycle.
    task automatic drive_packet(input logic [31:0] w, input int stall_pct, input int ss, input int sl,
                                input int ovr_cyc, input logic [31:0] ovr_word, input bit settle,
                                input string tag);
        int cyc, stalls, done_cyc, ovr_cnt;
        bit hold;
        logic [7:0] hold_dat;
        build_expected(w);
        got_q.delete();
        output_ready = 1'b1;
        average_data = w;
        tx_ready     = 1'($urandom);
        tick();
        cyc = 1; stalls = 0; done_cyc = -1; ovr_cnt = 0; hold = 1'b0; hold_dat = 8'h00;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        while (cyc < 64) begin
            if (overrun) ovr_cnt++;
            if (hold) begin
                check({tag, "_hold_data"}, 32'(tx_data), 32'(hold_dat));
                check({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
            end
            output_ready = (cyc == ovr_cyc);
            average_data = output_ready ? ovr_word : $urandom();
            if (packet_done) begin
                done_cyc = cyc;
                break;
            end
            tx_ready = !(cyc >= ss && cyc < ss + sl) && ($urandom_range(99) >= stall_pct);
            hold = 1'b0;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (tx_valid && !tx_ready) begin
                stalls++;
                hold = 1'b1;
                hold_dat = tx_data;
            end
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        tx_ready = 1'($urandom);
        tick();
        output_ready = 1'b0;
        if (overrun) ovr_cnt++;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_done_pulse"}, 32'(packet_done), 32'd0);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_latency"}, 32'(done_cyc), 32'(exp_q.size() + stalls + 1));
        check({tag, "_overrun_cnt"}, 32'(ovr_cnt), 32'(ovr_cyc > 0 ? 1 : 0));
        if (settle) begin
            repeat (3) tick();
            check({tag, "_no_new_pkt_valid"}, 32'(tx_valid), 32'd0);
            check({tag, "_no_new_pkt_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #2 n_rst = 1'b0;
        #1;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_packet_done", 32'(packet_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // Nominal packet, no backpressure
        drive_packet(32'h12345678, 0, 0, 0, -1, 32'h0, 1'b1, "basic");

        // Three stall cycles on the 0xAD byte (cycle 3)
        drive_packet(32'hDEADBEEF, 0, 3, 3, -1, 32'h0, 1'b1, "stall");

        // Load during the 2nd data byte is dropped
        drive_packet(32'h00000001, 0, 0, 0, 3, 32'hFFFFFFFF, 1'b1, "ovr_data");

        // Load in the DONE cycle is dropped
        drive_packet(32'hCAFEF00D, 0, 0, 0, PKT_LEN + 1, $urandom(), 1'b1, "ovr_done");

        // Reset mid-DATA abandons the packet
        output_ready = 1'b1;
        average_data = $urandom();
        tx_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        tick();
        tick();
        check("mid_pkt_valid", 32'(tx_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        check("arst_tx_data", 32'(tx_data), 32'h00);
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_packet_done", 32'(packet_done), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check("post_rst_valid", 32'(tx_valid), 32'd0);
        drive_packet(32'h00000000, 0, 0, 0, -1, 32'h0, 1'b1, "after_rst");

        // Back-to-back loads at minimum spacing
        drive_packet(32'h0BADBEEF, 0, 0, 0, -1, 32'h0, 1'b0, "b2b_a");
        drive_packet(32'h87654321, 0, 0, 0, -1, 32'h0, 1'b1, "b2b_b");

        // Random words with random backpressure
        for (int k = 0; k < 12; k++)
            drive_packet($urandom(), 35, 0, 0, -1, 32'h0, (k % 3) == 0, $sformatf("rnd%0d", k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
